uart_rx_frontend: RTL and testbench

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

---
 rtl/uart_defs.sv | 42 ++++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx_frontend.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared constants for the UART receive front end: FSM state codes, parity modes,
// oversampling geometry and small helpers used by the receiver and its tick generator.
package uart_defs;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  // Ticks within a bit whose samples vote on the bit value.
  localparam logic [TICK_W-1:0] SMP_A = TICK_W'(7);
  localparam logic [TICK_W-1:0] SMP_B = TICK_W'(8);
  localparam logic [TICK_W-1:0] SMP_C = TICK_W'(9);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef struct packed {
    logic valid;
    logic frame;
    logic parity;
    logic brk;
  } rx_status_t;

  // Clocks per oversample tick, rounded to nearest; never below 1.
  function automatic int baud_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, re-phased by restart_i.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CW'(DIV - 1));
    if (restart_i || tick_o) cnt_d = '0;
    else                     cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver: synchronizes the line, oversamples 16x with 2-of-3 voting per bit,
// and reports good bytes or frame/parity/break errors as single-cycle strobes.
module uart_rx_frontend
  import uart_defs::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 0,
  parameter int STOPBITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       uart_rxd,
  output logic       rx_data_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       break_det,
  output logic       busy
);

  localparam int   DIV       = baud_div(CLK_FREQ, BAUD);
  localparam logic LAST_STOP = (STOPBITS == 2);

  logic              rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TICK_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [1:0]        samp_q, samp_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              par_bad_q, par_bad_d;
  logic              stop_bad_q, stop_bad_d;
  rx_status_t        status_q, status_d;

  logic tick, start_edge, restart, bit_val, bit_done, par_exp, stop_bad_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  assign start_edge   = rxd_prev_q & ~rxd_s2_q;
  assign restart      = (state_q == ST_IDLE) & enable & start_edge;
  assign bit_val      = maj3(samp_q[0], samp_q[1], rxd_s2_q);
  assign bit_done     = tick & (tick_cnt_q == SMP_C);
  assign par_exp      = (PARITY == PAR_ODD) ? ~(^shreg_q) : ^shreg_q;
  assign stop_bad_now = stop_bad_q | ~bit_val;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    samp_d     = samp_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    status_d   = '0;

    if (state_q != ST_IDLE && !enable) begin
      state_d = ST_IDLE;
    end else begin
      if (state_q != ST_IDLE && tick) begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
        if (tick_cnt_q == SMP_A) samp_d[0] = rxd_s2_q;
        if (tick_cnt_q == SMP_B) samp_d[1] = rxd_s2_q;
      end
      // Bit decisions land on the third vote; the tick phase keeps running
      // across bits, so the next decision is exactly 16 ticks later.
      case (state_q)
        ST_IDLE: begin
          if (enable && start_edge) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
          end
        end
        ST_START: if (bit_done) state_d = bit_val ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (bit_done) begin
            shreg_d   = {bit_val, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            par_bad_d = (bit_val != par_exp);
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            stop_bad_d = stop_bad_now;
            if (stop_idx_q == LAST_STOP) begin
              if (stop_bad_now) begin
                status_d.frame  = 1'b1;
                status_d.brk    = (shreg_q == 8'h00);
                status_d.parity = par_bad_q;
                hi_cnt_d        = '0;
                state_d         = ST_WAIT_IDLE;
              end else if (par_bad_q) begin
                status_d.parity = 1'b1;
                state_d         = ST_IDLE;
              end else begin
                status_d.valid = 1'b1;
                rx_data_d      = shreg_q;
                state_d        = ST_IDLE;
              end
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (tick) begin
            if (!rxd_s2_q)                                 hi_cnt_d = '0;
            else if (hi_cnt_q == TICK_W'(OVERSAMPLE - 1)) state_d  = ST_IDLE;
            else                                           hi_cnt_d = hi_cnt_q + TICK_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      hi_cnt_q   <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      samp_q     <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      samp_q     <= samp_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
      status_q   <= status_d;
    end
  end

  assign rx_data_valid = status_q.valid;
  assign frame_err     = status_q.frame;
  assign parity_err    = status_q.parity;
  assign break_det     = status_q.brk;
  assign rx_data       = rx_data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: two instances (8N1 and 8E2) driven by a cycle-accurate
// serial sender; outcomes predicted from frame contents and compared per strobe event.
module tb_uart_rx_frontend;

  localparam int CLKF = 64_000_000;
  localparam int BR   = 1_000_000;
  localparam int DIV  = 4;          // round(64e6 / (1e6*16))
  localparam int BITC = 16 * DIV;   // clocks per nominal bit
  localparam int NSTR = 24;

  typedef struct {
    logic       v, f, p, b;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0, reset = 1'b0, enable = 1'b0, rxd_n = 1'b1, rxd_e = 1'b1;
  logic       vld_n, ferr_n, perr_n, brk_n, busy_n;
  logic       vld_e, ferr_e, perr_e, brk_e, busy_e;
  logic [7:0] data_n, data_e;

  int   checks = 0, errors = 0, cyc = 0, last_busy_n = 0;
  int   rd_n = 0, rd_e = 0, last_ev_cyc = 0;
  logic [7:0] last_n = 8'h00, last_e = 8'h00;
  ev_t  qn[$], qe[$];
  ev_t  mon_n, mon_e;

  uart_rx_frontend #(.CLK_FREQ(CLKF), .BAUD(BR), .PARITY(0), .STOPBITS(1)) dut_n (
    .clk(clk), .reset(reset), .enable(enable), .uart_rxd(rxd_n),
    .rx_data_valid(vld_n), .rx_data(data_n), .frame_err(ferr_n),
    .parity_err(perr_n), .break_det(brk_n), .busy(busy_n));

  uart_rx_frontend #(.CLK_FREQ(CLKF), .BAUD(BR), .PARITY(2), .STOPBITS(2)) dut_e (
    .clk(clk), .reset(reset), .enable(enable), .uart_rxd(rxd_e),
    .rx_data_valid(vld_e), .rx_data(data_e), .frame_err(ferr_e),
    .parity_err(perr_e), .break_det(brk_e), .busy(busy_e));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (vld_n | ferr_n | perr_n | brk_n) begin
      mon_n.v = vld_n; mon_n.f = ferr_n; mon_n.p = perr_n; mon_n.b = brk_n;
      mon_n.d = data_n; mon_n.cyc = cyc;
      qn.push_back(mon_n);
    end
    if (vld_e | ferr_e | perr_e | brk_e) begin
      mon_e.v = vld_e; mon_e.f = ferr_e; mon_e.p = perr_e; mon_e.b = brk_e;
      mon_e.d = data_e; mon_e.cyc = cyc;
      qe.push_back(mon_e);
    end
    if (busy_n) last_busy_n = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic val);
    if (sel == 0) rxd_n = val;
    else          rxd_e = val;
  endtask

  // Serial sender; bit edges placed at round-down multiples of the (skewed) bit time.
  task automatic send(input int sel, input logic [7:0] d, input logic pb,
                      input logic [1:0] sv, input int pct);
    logic bits[$];
    int   bl, t, target;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (sel != 0) bits.push_back(pb);
    bits.push_back(sv[0]);
    if (sel != 0) bits.push_back(sv[1]);
    bl = BITC * 10000 / (100 + pct);
    t  = 0;
    foreach (bits[k]) begin
      drive(sel, bits[k]);
      target = ((k + 1) * bl) / 100;
      while (t < target) begin
        @(posedge clk); #1;
        t++;
      end
    end
    drive(sel, 1'b1);
  endtask

  // Expected outcome from the frame contents alone.
  function automatic ev_t model(input int sel, input logic [7:0] d, input logic pb,
                                input logic [1:0] sv, input logic [7:0] last);
    ev_t  r;
    logic sb, pbad;
    sb   = (sv[0] == 1'b0) || (sel != 0 && sv[1] == 1'b0);
    pbad = (sel != 0) && (pb != (^d));
    r.v = !sb && !pbad;
    r.f = sb;
    r.p = pbad;
    r.b = sb && (d == 8'h00);
    r.d = r.v ? d : last;
    r.cyc = 0;
    return r;
  endfunction

  task automatic expect_ev(input int sel, input string tag, input int nexp, input ev_t e);
    int  n;
    ev_t g;
    n = (sel != 0) ? qe.size() - rd_e : qn.size() - rd_n;
    chk({tag, " count"}, n, nexp);
    if (nexp == 1 && n >= 1) begin
      g = (sel != 0) ? qe[rd_e] : qn[rd_n];
      chk({tag, " flags vfpb"}, 32'({g.v, g.f, g.p, g.b}), 32'({e.v, e.f, e.p, e.b}));
      chk({tag, " rx_data"}, g.d, e.d);
      last_ev_cyc = g.cyc;
    end
    if (sel != 0) rd_e += n;
    else          rd_n += n;
  endtask

  task automatic frame(input int sel, input logic [7:0] d, input logic pb,
                       input logic [1:0] sv, input int gap, input string tag);
    ev_t e;
    e = model(sel, d, pb, sv, (sel != 0) ? last_e : last_n);
    send(sel, d, pb, sv, 0);
    wait_cyc(gap);
    expect_ev(sel, tag, 1, e);
    if (e.v) begin
      if (sel != 0) last_e = d;
      else          last_n = d;
    end
  endtask

  task automatic stream(input int pct, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int         n;
    ev_t        g;
    for (int i = 0; i < NSTR; i++) begin
      d = (i == 0) ? 8'h00 : (i == NSTR - 1) ? 8'hFF : 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send(0, d, 1'b0, 2'b11, pct);
    end
    wait_cyc(2 * BITC);
    n = qn.size() - rd_n;
    chk({tag, " count"}, n, NSTR);
    for (int i = 0; i < NSTR && i < n; i++) begin
      g = qn[rd_n + i];
      chk($sformatf("%s[%0d] flags", tag, i), 32'({g.v, g.f, g.p, g.b}), 32'h8);
      chk($sformatf("%s[%0d] data", tag, i), g.d, exp_q[i]);
    end
    rd_n += n;
    last_n = exp_q[NSTR - 1];
    chk({tag, " held rx_data"}, data_n, last_n);
  endtask

  initial begin
    ev_t        none;
    int         t0;
    logic [7:0] d;
    logic       pb;
    logic [1:0] sv;
    none = '{v: 1'b0, f: 1'b0, p: 1'b0, b: 1'b0, d: 8'h00, cyc: 0};

    // Reset state
    wait_cyc(4);
    chk("reset busy_n", busy_n, 0);
    chk("reset busy_e", busy_e, 0);
    chk("reset rx_data_n", data_n, 0);
    chk("reset strobes_n", {vld_n, ferr_n, perr_n, brk_n}, 0);
    chk("reset strobes_e", {vld_e, ferr_e, perr_e, brk_e}, 0);
    reset = 1'b1; enable = 1'b1;
    wait_cyc(8);

    // Two good bytes; first also checks edge-to-strobe latency (stop bit center + 1 clock)
    t0 = cyc;
    frame(0, 8'hEB, 1'b0, 2'b11, 2 * BITC, "8N1 0xEB");
    chk("latency window", ((last_ev_cyc - t0) >= BITC * 9 + BITC / 2) && ((last_ev_cyc - t0) <= BITC * 10), 1);
    frame(0, 8'h90, 1'b0, 2'b11, 2 * BITC, "8N1 0x90");

    // Even parity: good 0x3C, then 0x07 with wrong parity bit 0
    frame(1, 8'h3C, 1'b0, 2'b11, 2 * BITC, "8E2 0x3C");
    frame(1, 8'h07, 1'b0, 2'b11, 2 * BITC, "8E2 0x07 bad parity");
    frame(1, 8'h11, 1'b0, 2'b01, 2 * BITC, "8E2 second stop low");
    frame(1, 8'h00, 1'b1, 2'b10, 2 * BITC, "8E2 parity+stop+break");

    // Break: 0x00, stop low, line held low 2 more bit times
    send(0, 8'h00, 1'b0, 2'b00, 0);
    drive(0, 1'b0);
    wait_cyc(2 * BITC);
    expect_ev(0, "break", 1, model(0, 8'h00, 1'b0, 2'b00, last_n));
    chk("break wait_idle busy", busy_n, 1);
    drive(0, 1'b1);
    wait_cyc(10 * DIV);
    chk("wait_idle 10 ticks high", busy_n, 1);
    wait_cyc(12 * DIV);
    chk("wait_idle 22 ticks high", busy_n, 0);
    frame(0, 8'h5A, 1'b0, 2'b11, 2 * BITC, "after break 0x5A");

    // 0.3-bit glitch
    t0 = cyc;
    drive(0, 1'b0);
    wait_cyc(BITC * 3 / 10);
    drive(0, 1'b1);
    wait_cyc(2 * BITC);
    chk("glitch busy seen", last_busy_n >= t0, 1);
    chk("glitch busy back low", busy_n, 0);
    expect_ev(0, "glitch", 0, none);

    // Disabled receiver ignores a whole frame
    enable = 1'b0;
    wait_cyc(2);
    t0 = cyc;
    send(0, 8'h33, 1'b0, 2'b11, 0);
    wait_cyc(2 * BITC);
    chk("disabled busy never", last_busy_n < t0, 1);
    expect_ev(0, "disabled", 0, none);
    enable = 1'b1;
    wait_cyc(4);

    // Enable dropped during bit 4 of 0x55, then 0xA5
    fork
      send(0, 8'h55, 1'b0, 2'b11, 0);
      begin
        wait_cyc(BITC * 5 + BITC / 2);
        enable = 1'b0;
        wait_cyc(1);
        chk("enable drop busy", busy_n, 0);
      end
    join
    wait_cyc(BITC);
    expect_ev(0, "enable drop", 0, none);
    enable = 1'b1;
    wait_cyc(4);
    frame(0, 8'hA5, 1'b0, 2'b11, 2 * BITC, "after drop 0xA5");

    // Reset mid-frame, held until the frame is over
    fork
      send(0, 8'hC3, 1'b0, 2'b11, 0);
      begin
        wait_cyc(BITC * 3);
        reset = 1'b0;
        #1;
        chk("mid reset busy", busy_n, 0);
        chk("mid reset rx_data", data_n, 0);
      end
    join
    wait_cyc(4);
    reset = 1'b1;
    last_n = 8'h00; last_e = 8'h00;
    wait_cyc(BITC);
    expect_ev(0, "mid reset", 0, none);
    frame(0, 8'h81, 1'b0, 2'b11, 2 * BITC, "after reset 0x81");

    // Random 8E2 frames with occasional bad parity / stop bits
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      sv = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
      frame(1, d, pb, sv, 2 * BITC, $sformatf("8E2 rnd%0d", i));
    end

    // Back-to-back streams at +3% and -3% baud
    stream(3, "stream+3");
    stream(-3, "stream-3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
